// File: rtl/apple_spawner.sv
// Apple spawner: LFSR apple placement, eat detection, respawn delay, score.
// Define APPLE_SCORE_BCD_EN for a two-digit BCD score (00..99).
module apple_spawner #(
  parameter int unsigned RESPAWN_TICKS = 2,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       tick,
  input  logic [9:0] head_x,
  input  logic [9:0] head_y,
  // rand is a reserved word, so the apple seed port is rnd
  output logic [7:0] rnd,
  output logic       refle,
  output logic       eat_pulse,
  output logic [7:0] score
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    EATEN,
    RESPAWN
  } state_t;

  localparam logic [3:0] RT = 4'(RESPAWN_TICKS);

  state_t     state;
  state_t     state_n;
  logic [7:0] lfsr;
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic [7:0] rnd_n;
  logic [7:0] score_n;
  logic [9:0] vu;
  logic [9:0] vd;
  logic [9:0] hl;
  logic [9:0] hr;
  logic       hit;

  function automatic logic [7:0] score_inc(input logic [7:0] s);
`ifdef APPLE_SCORE_BCD_EN
    if (s == 8'h99)
      return s;
    else if (s[3:0] == 4'd9)
      return {s[7:4] + 4'd1, 4'd0};
    else
      return {s[7:4], s[3:0] + 4'd1};
`else
    return (s == 8'hFF) ? s : s + 8'd1;
`endif
  endfunction

  assign vu  = {2'b00, rnd} + 10'd60;
  assign vd  = vu + 10'd15;
  assign hl  = {1'b0, rnd, 1'b0} + 10'd170;
  assign hr  = hl + 10'd15;
  assign hit = (head_x >= hl) && (head_x <= hr) &&
               (head_y >= vu) && (head_y <= vd);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rnd_n   = rnd;
    score_n = score;
    if (!start) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = ACTIVE;
          score_n = 8'd0;
        end
        ACTIVE: begin
          if (tick && hit) begin
            state_n = EATEN;
            score_n = score_inc(score);
          end
        end
        EATEN: begin
          state_n = RESPAWN;
          cnt_n   = 4'd0;
        end
        RESPAWN: begin
          if (tick) begin
            if (cnt + 4'd1 == RT) begin
              state_n = ACTIVE;
              rnd_n   = lfsr;
              cnt_n   = 4'd0;
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      rnd       <= LFSR_SEED;
      cnt       <= 4'd0;
      score     <= 8'd0;
      refle     <= 1'b0;
      eat_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      rnd       <= rnd_n;
      cnt       <= cnt_n;
      score     <= score_n;
      refle     <= (state_n == EATEN) || (state_n == RESPAWN);
      eat_pulse <= (state_n == EATEN);
    end
  end

endmodule

// File: tb/tb_apple_spawner.sv
// Bench for apple_spawner: scenario tasks plus randomized play
// against a behavioural model of the apple game.
module tb_apple_spawner;

  localparam int RT = 2;
  localparam logic [7:0] SEED = 8'hA5;
`ifdef APPLE_SCORE_BCD_EN
  localparam int NSAT = 100;
  localparam logic [7:0] SMAX = 8'h99;
`else
  localparam int NSAT = 256;
  localparam logic [7:0] SMAX = 8'hFF;
`endif

  logic       clk = 0;
  logic       rst_n = 0;
  logic       start = 0;
  logic       tick = 0;
  logic [9:0] head_x = 0;
  logic [9:0] head_y = 0;
  logic [7:0] rnd;
  logic       refle;
  logic       eat_pulse;
  logic [7:0] score;

  int checks = 0;
  int fails = 0;

  logic [7:0] m_lfsr = SEED;
  logic [7:0] m_rand = SEED;
  bit         m_on = 0;
  bit         m_fresh = 0;
  int         m_wait = 0;
  int         m_eats = 0;

  apple_spawner #(.RESPAWN_TICKS(RT), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick),
    .head_x(head_x), .head_y(head_y), .rnd(rnd),
    .refle(refle), .eat_pulse(eat_pulse), .score(score)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] exp_score(input int n);
    int c;
`ifdef APPLE_SCORE_BCD_EN
    c = (n > 99) ? 99 : n;
    return 8'((c / 10) * 16 + (c % 10));
`else
    c = (n > 255) ? 255 : n;
    return 8'(c);
`endif
  endfunction

  function automatic int box_hl(input logic [7:0] r);
    return 2 * int'(r) + 170;
  endfunction

  function automatic int box_vu(input logic [7:0] r);
    return int'(r) + 60;
  endfunction

  function automatic bit inside_box(input logic [7:0] r,
                                    input int x, input int y);
    int hl;
    int vu;
    hl = box_hl(r);
    vu = box_vu(r);
    return x >= hl && x <= hl + 15 && y >= vu && y <= vu + 15;
  endfunction

  // one clock: apply inputs, advance, then update the game model
  task automatic step(input bit s, input bit t, input int hx, input int hy);
    logic [7:0] prev;
    start  = s;
    tick   = t;
    head_x = 10'(hx);
    head_y = 10'(hy);
    @(posedge clk);
    #1;
    prev = m_lfsr;
    if (!rst_n) begin
      m_lfsr = SEED; m_rand = SEED; m_on = 0;
      m_fresh = 0; m_wait = 0; m_eats = 0;
    end else begin
      m_lfsr = lfsr_next(prev);
      if (!s) begin
        m_on = 0; m_fresh = 0; m_wait = 0;
      end else if (!m_on) begin
        m_on = 1; m_eats = 0;
      end else if (m_fresh) begin
        m_fresh = 0;
      end else if (m_wait > 0) begin
        if (t) begin
          m_wait--;
          if (m_wait == 0) m_rand = prev;
        end
      end else if (t && inside_box(m_rand, int'(head_x), int'(head_y))) begin
        m_eats++; m_fresh = 1; m_wait = RT;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    step(1, 1, 500, 240);
    step(1, 1, 500, 240);
    checks++; if (rnd !== 8'hA5) begin fails++; $display("FAIL reset_rand got %h want a5", rnd); end
    checks++; if (refle !== 1'b0) begin fails++; $display("FAIL reset_refle got %b want 0", refle); end
    checks++; if (eat_pulse !== 1'b0) begin fails++; $display("FAIL reset_eat got %b want 0", eat_pulse); end
    checks++; if (score !== 8'h00) begin fails++; $display("FAIL reset_score got %h want 00", score); end
    rst_n = 1;
  endtask

  task automatic test_start;
    step(1, 0, 0, 0);
    checks++; if (rnd !== 8'hA5) begin fails++; $display("FAIL start_rand got %h want a5", rnd); end
    checks++; if (refle !== 1'b0) begin fails++; $display("FAIL start_refle got %b want 0", refle); end
    checks++; if (score !== 8'h00) begin fails++; $display("FAIL start_score got %h want 00", score); end
  endtask

  task automatic test_eat_respawn;
    step(1, 1, 500, 240);
    checks++; if (eat_pulse !== 1'b1) begin fails++; $display("FAIL eat_pulse got %b want 1", eat_pulse); end
    checks++; if (refle !== 1'b1) begin fails++; $display("FAIL eat_refle got %b want 1", refle); end
    checks++; if (score !== 8'h01) begin fails++; $display("FAIL eat_score got %h want 01", score); end
    step(1, 1, 500, 240);
    checks++; if (eat_pulse !== 1'b0) begin fails++; $display("FAIL eat_once got %b want 0", eat_pulse); end
    checks++; if (refle !== 1'b1) begin fails++; $display("FAIL eaten_tick_refle got %b want 1", refle); end
    step(1, 1, 0, 0);
    checks++; if (refle !== 1'b1) begin fails++; $display("FAIL respawn_tick1 got %b want 1", refle); end
    step(1, 1, 0, 0);
    checks++; if (refle !== 1'b0) begin fails++; $display("FAIL respawn_tick2 got %b want 0", refle); end
    checks++; if (rnd !== m_rand) begin fails++; $display("FAIL respawn_rand got %h want %h", rnd, m_rand); end
  endtask

  task automatic respawn;
    repeat (RT + 1) step(1, 1, 0, 0);
    checks++; if (refle !== 1'b0) begin fails++; $display("FAIL respawn_done got %b want 0", refle); end
    checks++; if (rnd !== m_rand) begin fails++; $display("FAIL respawn_load got %h want %h", rnd, m_rand); end
  endtask

  task automatic test_edges;
    int hl;
    int vu;
    logic [7:0] s0;
    hl = box_hl(m_rand);
    vu = box_vu(m_rand);
    s0 = exp_score(m_eats);
    step(1, 1, hl - 1, vu + 15);
    step(1, 1, hl + 16, vu);
    step(1, 0, hl, vu);
    step(1, 1, hl, vu - 1);
    step(1, 1, hl + 15, vu + 16);
    checks++; if (score !== s0) begin fails++; $display("FAIL edge_miss_score got %h want %h", score, s0); end
    checks++; if (refle !== 1'b0) begin fails++; $display("FAIL edge_miss_refle got %b want 0", refle); end
    step(1, 1, hl + 15, vu + 15);
    checks++; if (eat_pulse !== 1'b1) begin fails++; $display("FAIL edge_hit_br got %b want 1", eat_pulse); end
    checks++; if (score !== exp_score(m_eats)) begin fails++; $display("FAIL edge_hit_score got %h want %h", score, exp_score(m_eats)); end
    respawn();
    step(1, 1, box_hl(m_rand), box_vu(m_rand));
    checks++; if (eat_pulse !== 1'b1) begin fails++; $display("FAIL edge_hit_tl got %b want 1", eat_pulse); end
    respawn();
  endtask

  task automatic test_start_drop;
    logic [7:0] s0;
    step(1, 1, box_hl(m_rand) + 7, box_vu(m_rand) + 3);
    s0 = exp_score(m_eats);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    checks++; if (refle !== 1'b0) begin fails++; $display("FAIL drop_refle got %b want 0", refle); end
    checks++; if (score !== s0) begin fails++; $display("FAIL drop_score got %h want %h", score, s0); end
    checks++; if (rnd !== m_rand) begin fails++; $display("FAIL drop_rand got %h want %h", rnd, m_rand); end
    step(1, 0, 0, 0);
    checks++; if (score !== 8'h00) begin fails++; $display("FAIL restart_score got %h want 00", score); end
    checks++; if (refle !== 1'b0) begin fails++; $display("FAIL restart_refle got %b want 0", refle); end
  endtask

  task automatic test_reset_mid;
    step(1, 1, box_hl(m_rand), box_vu(m_rand) + 15);
    step(1, 0, 0, 0);
    rst_n = 0;
    step(1, 1, 0, 0);
    checks++; if (rnd !== 8'hA5) begin fails++; $display("FAIL midrst_rand got %h want a5", rnd); end
    checks++; if (refle !== 1'b0) begin fails++; $display("FAIL midrst_refle got %b want 0", refle); end
    checks++; if (eat_pulse !== 1'b0) begin fails++; $display("FAIL midrst_eat got %b want 0", eat_pulse); end
    checks++; if (score !== 8'h00) begin fails++; $display("FAIL midrst_score got %h want 00", score); end
    rst_n = 1;
  endtask

  // the seed loaded 255 clocks after reset must come back as a5
  task automatic test_lfsr_period;
    step(1, 0, 0, 0);
    repeat (251) step(1, 0, 0, 0);
    step(1, 1, 500, 240);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    checks++; if (rnd !== 8'hA5) begin fails++; $display("FAIL lfsr_period got %h want a5", rnd); end
    checks++; if (refle !== 1'b0) begin fails++; $display("FAIL lfsr_refle got %b want 0", refle); end
  endtask

  task automatic test_random;
    bit s;
    bit t;
    int hx;
    int hy;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 19) != 0);
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin
        hx = box_hl(m_rand) - 2 + int'($urandom_range(0, 19));
        hy = box_vu(m_rand) - 2 + int'($urandom_range(0, 19));
      end else begin
        hx = int'($urandom_range(0, 1023));
        hy = int'($urandom_range(0, 1023));
      end
      rst_n = ($urandom_range(0, 199) != 0);
      step(s, t, hx, hy);
      checks++; if (rnd !== m_rand) begin fails++; $display("FAIL rand_rnd cyc %0d got %h want %h", i, rnd, m_rand); end
      checks++; if (refle !== (m_fresh || m_wait > 0)) begin fails++; $display("FAIL rand_refle cyc %0d got %b want %b", i, refle, m_fresh || m_wait > 0); end
      checks++; if (eat_pulse !== m_fresh) begin fails++; $display("FAIL rand_eat cyc %0d got %b want %b", i, eat_pulse, m_fresh); end
      checks++; if (score !== exp_score(m_eats)) begin fails++; $display("FAIL rand_score cyc %0d got %h want %h", i, score, exp_score(m_eats)); end
    end
    rst_n = 1;
  endtask

  task automatic test_saturation;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < NSAT; i++) begin
      step(1, 1, box_hl(m_rand) + int'($urandom_range(0, 15)),
           box_vu(m_rand) + int'($urandom_range(0, 15)));
      if (i == 9 || i == 42) begin
        checks++; if (score !== exp_score(m_eats)) begin fails++; $display("FAIL sat_mid got %h want %h", score, exp_score(m_eats)); end
      end
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
    end
    checks++; if (score !== SMAX) begin fails++; $display("FAIL sat_score got %h want %h", score, SMAX); end
    step(1, 1, box_hl(m_rand), box_vu(m_rand));
    checks++; if (eat_pulse !== 1'b1) begin fails++; $display("FAIL sat_eat got %b want 1", eat_pulse); end
    checks++; if (score !== SMAX) begin fails++; $display("FAIL sat_hold got %h want %h", score, SMAX); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_eat_respawn();
    test_edges();
    test_start_drop();
    test_reset_mid();
    test_lfsr_period();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/apple_spawner.md
APPLE_SPAWNER -- requirements
Module: apple_spawner

Interface
REQ-001 SHALL have parameter RESPAWN_TICKS, default 2: number of game ticks the apple stays hidden after being eaten (legal range 1..15).
REQ-002 SHALL have parameter LFSR_SEED, default 8'hA5: LFSR and rand reset value; must be nonzero.
REQ-003 SHALL have port clk  input  1: single system clock; all state on the rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1: game running; 0 = idle.
REQ-006 SHALL have port tick  input  1: one-clk game-step strobe.
REQ-007 SHALL have ports head_x, head_y  input  10 each: snake-head pixel position.
REQ-008 SHALL have port rand  output  8: apple position seed, consumed by the apple-box stage.
REQ-009 SHALL have port refle  output  1: apple hidden/eaten flag, consumed by the apple-box stage (1 = blank the apple).
REQ-010 SHALL have port eat_pulse  output  1: one-clk strobe per apple eaten.
REQ-011 SHALL have port score  output  8: apples eaten.

Function
REQ-012 SHALL run an 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances every clk while rst_n=1, independent of state; it never reaches zero.
REQ-013 SHALL hold rand (registered) constant except on the RESPAWN->ACTIVE transition, where rand loads the current LFSR value.
REQ-014 SHALL derive the apple box internally with 10-bit, zero-extended arithmetic: Vu=rand+60, Vd=Vu+15, Hl=2*rand+170, Hr=Hl+15.
REQ-015 SHALL define a hit as Hl<=head_x<=Hr AND Vu<=head_y<=Vd, inclusive on all four edges.
REQ-016 SHALL implement the FSM with states IDLE, ACTIVE, EATEN, RESPAWN.
REQ-017 In IDLE, the FSM SHALL move to ACTIVE on the next clk when start=1, and clear score on that transition.
REQ-018 In ACTIVE, when tick=1 and hit=1, the FSM SHALL move to EATEN; no hit is evaluated when tick=0.
REQ-019 EATEN SHALL last exactly one clk: eat_pulse=1, score increments by 1, then the FSM moves to RESPAWN with the tick counter cleared.
REQ-020 RESPAWN SHALL count ticks and move to ACTIVE on the clk where the counter reaches RESPAWN_TICKS.
REQ-021 refle SHALL be 1 in EATEN and RESPAWN and 0 in IDLE and ACTIVE; the output is registered and state-decoded.
REQ-022 start=0 in any state SHALL force IDLE on the next clk, with priority over tick/hit; score and rand are held.
REQ-023 A tick arriving in the same clk as the EATEN cycle SHALL NOT count toward RESPAWN.
REQ-024 score SHALL saturate at its maximum value; eat_pulse still fires at saturation.

Reset
REQ-025 When rst_n=0 at a clk edge, the block SHALL set state=IDLE, LFSR=LFSR_SEED, rand=LFSR_SEED, refle=0, eat_pulse=0, score=0, and tick counter=0.
REQ-026 Reset SHALL take effect from any state, including mid-RESPAWN, and override start/tick in the same cycle.

Configuration
REQ-027 With macro APPLE_SCORE_BCD_EN defined, score SHALL be two packed BCD digits counting 00..99 with decimal carry, saturating at 8'h99.
REQ-028 Without APPLE_SCORE_BCD_EN, score SHALL be plain binary 0..255, saturating at 8'hFF.

Verification
REQ-029 Scenario: reset, then start=1 -> rand=8'hA5, box Hl=500/Hr=515/Vu=225/Vd=240, state ACTIVE, refle=0.
REQ-030 Scenario: ACTIVE, head=(500,240), tick -> next clk eat_pulse=1, refle=1, score=1; with RESPAWN_TICKS=2, refle=0 one clk after the 2nd tick, and rand equals the LFSR value at that edge.
REQ-031 Scenario: head=(499,240) or (516,225), tick -> no hit, score unchanged; head inside with tick=0 -> no hit.
REQ-032 Scenario: start dropped during RESPAWN -> IDLE next clk, refle=0, score held; start=1 again -> score=0.
REQ-033 Scenario: rst_n=0 during RESPAWN -> all outputs at reset values next clk; LFSR run for 255 clks -> returns to 8'hA5, never 0.
REQ-034 Scenario: 100 eats with BCD_EN -> score=8'h99; without BCD_EN, 256 eats -> score=8'hFF.
